// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART packet parser feeding the ALU datapath.
package uart_alu_pkg;

    typedef enum logic [2:0] {
        S_OP   = 3'd0,
        S_RSV  = 3'd1,
        S_LLO  = 3'd2,
        S_LHI  = 3'd3,
        S_DATA = 3'd4
    } parser_state_e;

    localparam logic [7:0]  OP_ECHO   = 8'h10;
    localparam logic [7:0]  OP_ADD    = 8'h20;
    localparam logic [7:0]  OP_MUL    = 8'h21;
    localparam logic [7:0]  OP_DIV    = 8'h22;
    localparam logic [15:0] HDR_BYTES = 16'd4;

    function automatic logic opcode_known(input logic [7:0] op);
        return (op == OP_ECHO) || (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs payload bytes into little-endian words (byte 0 in the LSBs) and holds
// each finished word in a single-entry valid/ready output register.
module byte_packer #(
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [7:0]              data_i,
    input  logic                    push_i,
    input  logic                    last_i,
    input  logic                    zero_i,
    input  logic                    first_i,
    output logic                    emit_o,
    output logic [8*WORD_BYTES-1:0] word_o,
    output logic                    first_o,
    output logic                    last_o,
    output logic                    valid_o,
    input  logic                    ready_i
);
    localparam int unsigned   LW       = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int unsigned   WW       = 8 * WORD_BYTES;
    localparam logic [LW-1:0] LANE_MAX = LW'(WORD_BYTES - 1);

    logic [WW-1:0] pack_q, pack_d, merged_s, word_q, word_d;
    logic [LW-1:0] lane_q, lane_d;
    logic          first_q, first_d, last_q, last_d, valid_q, valid_d, emit_s;

    // Lane fill: high lanes stay zero because the pack register clears after every emit.
    always_comb begin
        merged_s = pack_q;
        merged_s[{lane_q, 3'b000} +: 8] = data_i;
        pack_d = pack_q;
        lane_d = lane_q;
        emit_s = 1'b0;
        if (zero_i) begin
            emit_s = 1'b1;
        end else if (push_i) begin
            if ((lane_q == LANE_MAX) || last_i) begin
                emit_s = 1'b1;
                pack_d = '0;
                lane_d = '0;
            end else begin
                pack_d = merged_s;
                lane_d = lane_q + LW'(1'b1);
            end
        end else begin
            pack_d = pack_q;
        end
    end

    // Output register: a load only ever arrives while empty or draining.
    always_comb begin
        word_d  = word_q;
        first_d = first_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (emit_s) begin
            word_d  = zero_i ? '0 : merged_s;
            first_d = first_i;
            last_d  = zero_i | last_i;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            word_d  = '0;
            first_d = 1'b0;
            last_d  = 1'b0;
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pack_q  <= '0;
            lane_q  <= '0;
            word_q  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            pack_q  <= pack_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            first_q <= first_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign emit_o  = emit_s;
    assign word_o  = word_q;
    assign first_o = first_q;
    assign last_o  = last_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/uart_pkt_parser.sv
// Parses opcode/reserved/length header from the UART byte stream and forwards packed payload words.
// Build option: define PKT_OPCODE_CHECK_EN to flag and discard packets with unknown opcodes.
module uart_pkt_parser
    import uart_alu_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 4,
    parameter logic [15:0] MAX_LEN    = 16'hFFFF
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [7:0]              s_data_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [7:0]              m_opcode_o,
    output logic [8*WORD_BYTES-1:0] m_word_o,
    output logic                    m_first_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic                    err_o
);
    parser_state_e state_q, state_d;
    logic [7:0]    opcode_q, opcode_d, len_lo_q, len_lo_d;
    logic [15:0]   cnt_q, cnt_d, len_s;
    logic          first_pend_q, first_pend_d, err_q, err_d;
    logic          byte_fire_s, len_ok_s, len_empty_s, final_s;
    logic          op_bad_s, drop_s, push_s, zero_s, emit_s;

    assign s_ready_o   = !(m_valid_o && !m_ready_i);
    assign byte_fire_s = s_valid_i && s_ready_o;
    assign len_s       = {s_data_i, len_lo_q};
    assign len_ok_s    = (len_s >= HDR_BYTES) && ({16'h0000, len_s} <= {16'h0000, MAX_LEN});
    assign len_empty_s = (len_s == HDR_BYTES);
    assign final_s     = (cnt_q <= 16'd1);

`ifdef PKT_OPCODE_CHECK_EN
    logic drop_q, drop_d;
    assign op_bad_s = !opcode_known(s_data_i);
    assign drop_s   = drop_q;

    always_comb begin
        if (byte_fire_s && (state_q == S_OP)) begin
            drop_d = op_bad_s;
        end else begin
            drop_d = drop_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop_d;
        end
    end
`else
    assign op_bad_s = 1'b0;
    assign drop_s   = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_OP;
        end else begin
            state_q <= state_d;
        end
    end

    // Header bytes always advance; a bad or empty length returns straight to S_OP.
    always_comb begin
        state_d = state_q;
        if (byte_fire_s) begin
            case (state_q)
                S_OP:    state_d = S_RSV;
                S_RSV:   state_d = S_LLO;
                S_LLO:   state_d = S_LHI;
                S_LHI:   state_d = (len_ok_s && !len_empty_s) ? S_DATA : S_OP;
                S_DATA:  state_d = final_s ? S_OP : S_DATA;
                default: state_d = S_OP;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    always_comb begin
        err_d  = 1'b0;
        push_s = 1'b0;
        zero_s = 1'b0;
        if (byte_fire_s) begin
            case (state_q)
                S_OP:   err_d = op_bad_s;
                S_RSV:  err_d = (s_data_i != 8'h00);
                S_LHI: begin
                    err_d  = !len_ok_s;
                    zero_s = len_ok_s && len_empty_s && !drop_s;
                end
                S_DATA:  push_s = !drop_s;
                default: err_d = 1'b0;
            endcase
        end else begin
            err_d = 1'b0;
        end
    end

    // Header fields and the payload down-counter; first flag arms for each new packet.
    always_comb begin
        opcode_d     = opcode_q;
        len_lo_d     = len_lo_q;
        cnt_d        = cnt_q;
        first_pend_d = emit_s ? 1'b0 : first_pend_q;
        if (byte_fire_s) begin
            case (state_q)
                S_OP:  opcode_d = s_data_i;
                S_LLO: len_lo_d = s_data_i;
                S_LHI: begin
                    cnt_d        = len_ok_s ? (len_s - HDR_BYTES) : 16'd0;
                    first_pend_d = len_ok_s && !len_empty_s;
                end
                S_DATA:  cnt_d = (cnt_q != 16'd0) ? (cnt_q - 16'd1) : cnt_q;
                default: cnt_d = cnt_q;
            endcase
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            opcode_q     <= 8'h00;
            len_lo_q     <= 8'h00;
            cnt_q        <= 16'd0;
            first_pend_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            opcode_q     <= opcode_d;
            len_lo_q     <= len_lo_d;
            cnt_q        <= cnt_d;
            first_pend_q <= first_pend_d;
            err_q        <= err_d;
        end
    end

    byte_packer #(.WORD_BYTES(WORD_BYTES)) u_packer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .data_i  (s_data_i),
        .push_i  (push_s),
        .last_i  (final_s),
        .zero_i  (zero_s),
        .first_i (first_pend_q | zero_s),
        .emit_o  (emit_s),
        .word_o  (m_word_o),
        .first_o (m_first_o),
        .last_o  (m_last_o),
        .valid_o (m_valid_o),
        .ready_i (m_ready_i)
    );

    assign m_opcode_o = opcode_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Self-checking bench for uart_pkt_parser: directed vector table, stall/reset sequences,
// and a randomized packet stream checked against a packet-level reference model.
module tb_uart_pkt_parser;
    localparam int WB = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [7:0]  s_data_i = 8'h00;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o;
    logic [7:0]  m_opcode_o;
    logic [31:0] m_word_o;
    logic        m_first_o, m_last_o, m_valid_o;
    logic        m_ready_i;
    logic        err_o;

    uart_pkt_parser #(.WORD_BYTES(WB), .MAX_LEN(16'hFFFF)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .s_data_i(s_data_i), .s_valid_i(s_valid_i),
        .s_ready_o(s_ready_o), .m_opcode_o(m_opcode_o), .m_word_o(m_word_o),
        .m_first_o(m_first_o), .m_last_o(m_last_o), .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] w;
        logic        f;
        logic        l;
    } wrd_t;

    typedef struct {
        int          nb;
        logic [95:0] bytes;
        logic [7:0]  op;
        int          nw;
        logic [63:0] words;
        int          errs;
    } vec_t;

    wrd_t got_q[$];
    wrd_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   err_cnt = 0;
    int   ready_mode = 0;
    int   gap_en = 0;
    int   stall_cycles = 0;
    int   unstable = 0;

    // Output monitor: a word transfers at the next posedge when valid and ready are both high here.
    initial begin
        wrd_t e;
        forever begin
            @(negedge clk_i);
            if (rst_ni && m_valid_o && m_ready_i) begin
                e.op = m_opcode_o; e.w = m_word_o; e.f = m_first_o; e.l = m_last_o;
                got_q.push_back(e);
            end
            if (rst_ni && err_o) err_cnt++;
        end
    end

    initial begin
        m_ready_i = 1'b1;
        forever begin
            @(posedge clk_i); #1;
            case (ready_mode)
                0:       m_ready_i = 1'b1;
                1:       m_ready_i = 1'($urandom_range(0, 1));
                default: m_ready_i = 1'b0;
            endcase
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        s_data_i = b;
        s_valid_i = 1'b1;
        @(negedge clk_i);
        while (!s_ready_o && k < 2000) begin
            k++;
            @(negedge clk_i);
        end
        if (!s_ready_o) begin
            n_cmp++; n_bad++;
            $display("FAIL byte_timeout: byte %h not accepted, required acceptance", b);
        end
        @(posedge clk_i); #1;
        s_valid_i = 1'b0;
        if (gap_en != 0) repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
    endtask

    task automatic send_pkt(input logic [7:0] pk[$]);
        foreach (pk[i]) send_byte(pk[i]);
    endtask

    task automatic drain(input int n);
        int k;
        k = 0;
        while ((got_q.size() < n || m_valid_o) && k < 2000) begin
            @(posedge clk_i); #1;
            k++;
        end
        if (k >= 2000) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got %0d words required %0d", got_q.size(), n);
        end
        repeat (3) begin @(posedge clk_i); #1; end
    endtask

    task automatic compare_words(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_w%0d_op", tag, i), {24'h0, got_q[i].op}, {24'h0, exp_q[i].op});
            chk($sformatf("%s_w%0d_word", tag, i), got_q[i].w, exp_q[i].w);
            chk($sformatf("%s_w%0d_first", tag, i), {31'h0, got_q[i].f}, {31'h0, exp_q[i].f});
            chk($sformatf("%s_w%0d_last", tag, i), {31'h0, got_q[i].l}, {31'h0, exp_q[i].l});
        end
    endtask

    // Packet-level reference: appends expected words to exp_q and returns the expected err pulses.
    function automatic int model_pkt(input logic [7:0] op, input logic [7:0] rsv, input int len,
                                     input logic [7:0] pl[$]);
        int   errs;
        int   n;
        int   nwords;
        bit   bad_op;
        wrd_t e;
        errs = 0;
`ifdef PKT_OPCODE_CHECK_EN
        bad_op = !(op inside {8'h10, 8'h20, 8'h21, 8'h22});
`else
        bad_op = 1'b0;
`endif
        if (bad_op) errs++;
        if (rsv != 8'h00) errs++;
        if (len < 4 || len > 65535) return errs + 1;
        if (bad_op) return errs;
        n = len - 4;
        e.op = op;
        if (n == 0) begin
            e.w = 32'h0; e.f = 1'b1; e.l = 1'b1;
            exp_q.push_back(e);
            return errs;
        end
        nwords = (n + WB - 1) / WB;
        for (int k = 0; k < nwords; k++) begin
            e.w = 32'h0;
            for (int j = 0; j < WB; j++)
                if (k * WB + j < n) e.w[j*8 +: 8] = pl[k * WB + j];
            e.f = (k == 0);
            e.l = (k == nwords - 1);
            exp_q.push_back(e);
        end
        return errs;
    endfunction

    vec_t vecs [8];

    initial begin
        logic [7:0]  pk[$];
        logic [7:0]  pl[$];
        logic [95:0] tb;
        logic [63:0] tw;
        logic [31:0] held;
        logic [7:0]  op, rsv;
        logic [15:0] len16;
        int          len, exp_err, r;
        wrd_t        e;

        vecs[0] = '{12, 96'h20000C00_01000000_02000000, 8'h20, 2, 64'h00000002_00000001, 0};
        vecs[1] = '{7,  96'h10000700_AABBCC,            8'h10, 1, 64'h00000000_00CCBBAA, 0};
        vecs[2] = '{4,  96'h21000400,                   8'h21, 1, 64'h0,                 0};
        vecs[3] = '{4,  96'h21000200,                   8'h21, 0, 64'h0,                 1};
        vecs[4] = '{5,  96'h10050500_77,                8'h10, 1, 64'h00000000_00000077, 1};
        vecs[5] = '{8,  96'h22000800_05000000,          8'h22, 1, 64'h00000000_00000005, 0};
`ifdef PKT_OPCODE_CHECK_EN
        vecs[6] = '{8,  96'h7F000800_01020304,          8'h7F, 0, 64'h0,                 1};
`else
        vecs[6] = '{8,  96'h7F000800_01020304,          8'h7F, 1, 64'h00000000_04030201, 0};
`endif
        vecs[7] = '{4,  96'h20000000,                   8'h20, 0, 64'h0,                 1};

        // Reset state
        #1;
        chk("rst_s_ready", {31'h0, s_ready_o}, 32'd1);
        chk("rst_m_valid", {31'h0, m_valid_o}, 32'd0);
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("rst_m_word", m_word_o, 32'h0);
        chk("rst_m_opcode", {24'h0, m_opcode_o}, 32'h0);
        chk("rst_flags", {28'h0, m_first_o, m_last_o, err_o, m_valid_o}, 32'h0);

        // Directed vector table
        for (int v = 0; v < 8; v++) begin
            got_q.delete(); exp_q.delete(); pk.delete(); err_cnt = 0;
            tb = vecs[v].bytes;
            tw = vecs[v].words;
            for (int i = 0; i < vecs[v].nb; i++) pk.push_back(tb[(vecs[v].nb - 1 - i) * 8 +: 8]);
            for (int k = 0; k < vecs[v].nw; k++) begin
                e.op = vecs[v].op; e.w = tw[k*32 +: 32];
                e.f = (k == 0); e.l = (k == vecs[v].nw - 1);
                exp_q.push_back(e);
            end
            send_pkt(pk);
            drain(vecs[v].nw);
            compare_words($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_errs", v), err_cnt, vecs[v].errs);
        end

        // Backpressure: ALU stalls 50 cycles while 8 payload bytes stream in
        got_q.delete(); exp_q.delete(); err_cnt = 0; pl.delete();
        for (int i = 1; i <= 8; i++) pl.push_back(8'(i));
        exp_err = model_pkt(8'h20, 8'h00, 12, pl);
        pk = {8'h20, 8'h00, 8'h0C, 8'h00};
        pk = {pk, pl};
        ready_mode = 2;
        stall_cycles = 0; unstable = 0;
        @(posedge clk_i); #1;
        fork
            send_pkt(pk);
            begin
                held = 32'h0;
                repeat (50) begin
                    @(negedge clk_i);
                    if (m_valid_o && !s_ready_o) begin
                        if (stall_cycles > 0 && m_word_o !== held) unstable++;
                        held = m_word_o;
                        stall_cycles++;
                    end
                end
                chk("bp_held_word", m_word_o, 32'h04030201);
                chk("bp_held_first", {31'h0, m_first_o}, 32'd1);
                ready_mode = 0;
            end
        join
        drain(exp_q.size());
        chk("bp_stall_seen", {31'h0, stall_cycles > 0}, 32'd1);
        chk("bp_stable", unstable, 32'd0);
        compare_words("bp");
        chk("bp_errs", err_cnt, exp_err);

        // Reset with a held word, then reset mid-packet
        got_q.delete(); exp_q.delete(); err_cnt = 0;
        ready_mode = 2;
        @(posedge clk_i); #1;
        send_pkt('{8'h10, 8'h00, 8'h05, 8'h00, 8'h99});
        repeat (3) begin @(posedge clk_i); #1; end
        chk("pre_rst_valid", {31'h0, m_valid_o}, 32'd1);
        chk("pre_rst_word", m_word_o, 32'h00000099);
        rst_ni = 1'b0;
        #1;
        chk("async_rst_valid", {31'h0, m_valid_o}, 32'd0);
        chk("async_rst_word", m_word_o, 32'h0);
        chk("async_rst_s_ready", {31'h0, s_ready_o}, 32'd1);
        ready_mode = 0;
        @(posedge clk_i); #1 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        send_pkt('{8'h20, 8'h00, 8'h0C, 8'h00, 8'h11, 8'h22});
        rst_ni = 1'b0;
        repeat (2) begin @(posedge clk_i); #1; end
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        got_q.delete(); err_cnt = 0;
        e.op = 8'h22; e.w = 32'h00000005; e.f = 1'b1; e.l = 1'b1;
        exp_q.push_back(e);
        send_pkt('{8'h22, 8'h00, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00});
        drain(1);
        compare_words("rst_mid");
        chk("rst_mid_errs", err_cnt, 32'd0);

        // Randomized stream with random ALU stalls and inter-byte gaps
        got_q.delete(); exp_q.delete(); err_cnt = 0; exp_err = 0;
        ready_mode = 1; gap_en = 1;
        for (int p = 0; p < 40; p++) begin
            r = $urandom_range(0, 9);
            case ($urandom_range(0, 3))
                0: op = 8'h10;
                1: op = 8'h20;
                2: op = 8'h21;
                default: op = 8'h22;
            endcase
            if (r >= 8) op = 8'($urandom_range(0, 255));
            rsv = ($urandom_range(0, 14) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : 4 + $urandom_range(0, 17);
            len16 = 16'(len);
            pl.delete();
            if (len >= 4) for (int i = 0; i < len - 4; i++) pl.push_back(8'($urandom_range(0, 255)));
            exp_err += model_pkt(op, rsv, len, pl);
            pk = {op, rsv, len16[7:0], len16[15:8]};
            pk = {pk, pl};
            send_pkt(pk);
        end
        drain(exp_q.size());
        compare_words("rand");
        chk("rand_errs", err_cnt, exp_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
